// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Optional macro MULDIV_SIGNED_EN adds two's-complement operation selected by is_signed.

module muldiv_unit #(
  parameter  int DATA_W = 16,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [4:0]        waddr_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              reg_write_o,
  output logic [4:0]        waddr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  // acc holds the product high half or the partial remainder; lo holds the
  // product low half / multiplier or the dividend shifting into the quotient.
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   opd_q, opd_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [4:0]          waddr_out_q, waddr_out_d;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                div_zero;

`ifdef MULDIV_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;

  assign sign_a = is_signed & operand_a[DATA_W-1];
  assign sign_b = is_signed & operand_b[DATA_W-1];
  assign a_mag  = sign_a ? -operand_a : operand_a;
  assign b_mag  = sign_b ? -operand_b : operand_b;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag = operand_a;
  assign b_mag = operand_b;
`endif

  assign div_zero = op[1] && (operand_b == '0);

  // Single iteration of the active algorithm
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic [DATA_W-1:0] acc_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_q, lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    acc_step  = mul_sum[DATA_W:1];
    lo_step   = {mul_sum[0], lo_q[DATA_W-1:1]};
    if (op_q[1]) begin
      if (!div_diff[DATA_W]) begin
        acc_step = div_diff[DATA_W-1:0];
        lo_step  = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = div_shift[DATA_W-1:0];
        lo_step  = {lo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Result as it will be after the final iteration, sign-corrected when enabled
  logic [2*DATA_W-1:0] prod_fin;
  logic [DATA_W-1:0]   quo_fin, rem_fin, res_fin;

  always_comb begin
    prod_fin = {acc_step, lo_step};
    quo_fin  = lo_step;
    rem_fin  = acc_step;
    res_fin  = '0;
`ifdef MULDIV_SIGNED_EN
    if (neg_res_q) begin
      prod_fin = -prod_fin;
      quo_fin  = -quo_fin;
    end
    if (neg_rem_q) begin
      rem_fin = -rem_fin;
    end
`endif
    case (op_q)
      2'b00:   res_fin = prod_fin[DATA_W-1:0];
      2'b01:   res_fin = prod_fin[2*DATA_W-1:DATA_W];
      2'b10:   res_fin = quo_fin;
      default: res_fin = rem_fin;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opd_d       = opd_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          waddr_d = waddr_in;
          cnt_d   = '0;
          acc_d   = '0;
          if (op[1]) begin
            lo_d  = a_mag;
            opd_d = b_mag;
          end else begin
            lo_d  = b_mag;
            opd_d = a_mag;
          end
`ifdef MULDIV_SIGNED_EN
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
`endif
          if (div_zero) begin
            state_d     = S_DONE;
            result_d    = op[0] ? operand_a : '1;
            waddr_out_d = waddr_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = S_DONE;
          result_d    = res_fin;
          waddr_out_d = waddr_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opd_q       <= '0;
      waddr_q     <= '0;
      result_q    <= '0;
      waddr_out_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opd_q       <= opd_d;
      waddr_q     <= waddr_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign reg_write_o = done;
  assign result      = result_q;
  assign waddr_o     = waddr_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for muldiv_unit: expected results queued at issue, checked by a monitor on done.

module tb_muldiv_unit;
  localparam int W = 16;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         is_signed = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [4:0]   waddr_in = '0;
  logic         busy, done, reg_write_o;
  logic [W-1:0] result;
  logic [4:0]   waddr_o;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .op(op), .is_signed(is_signed),
    .operand_a(operand_a), .operand_b(operand_b), .waddr_in(waddr_in),
    .busy(busy), .done(done), .result(result), .reg_write_o(reg_write_o),
    .waddr_o(waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   wa;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic s,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned up;
    longint          sp;
    int              sa, sbv, q, r;
    if (s && SIGNED_EN) begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      sp  = longint'(sa) * longint'(sbv);
      case (o)
        2'b00: return sp[W-1:0];
        2'b01: return sp[2*W-1:W];
        default: begin
          if (sbv == 0) return (o == 2'b10) ? {W{1'b1}} : a;
          if (sa == -(1 << (W-1)) && sbv == -1) return (o == 2'b10) ? a : '0;
          q = sa / sbv;
          r = sa % sbv;
          return (o == 2'b10) ? q[W-1:0] : r[W-1:0];
        end
      endcase
    end
    up = longint'(a) * longint'(b);
    case (o)
      2'b00: return up[W-1:0];
      2'b01: return up[2*W-1:W];
      2'b10: return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (arst_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: done pulse with no outstanding op, result=0x%0h at %0t", result, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("waddr_o", waddr_o, e.wa);
        check("reg_write_o", reg_write_o, done);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] wa,
                       input logic [W-1:0] exp_res, input bit poke);
    int lat;
    int exp_lat;
    @(negedge clk);
    op = o; is_signed = s; operand_a = a; operand_b = b; waddr_in = wa;
    start = 1'b1;
    sb_q.push_back('{res: exp_res, wa: wa});
    exp_lat = (o[1] && b == 0) ? 1 : W + 1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = W'($urandom); operand_b = W'($urandom);
    op = 2'($urandom); waddr_in = 5'($urandom);
    check("busy_after_start", busy, 1);
    lat = 1;
    while (!done && lat < 3 * W) begin
      if (poke) start = (lat >= 2 && lat <= 5);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   ro;
    logic         rs;
    logic [W-1:0] ra, rb;
    logic [4:0]   rw;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_reg_write", reg_write_o, 0);
    check("rst_result", result, 0);
    check("rst_waddr_o", waddr_o, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(2'b00, 1'b0, 16'd3,    16'd5,    5'd7,  16'h000F, 1'b0);
    issue(2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 5'd3,  16'hFFFE, 1'b0);
    issue(2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 5'd4,  16'h0001, 1'b0);
    issue(2'b10, 1'b0, 16'd100,  16'd7,    5'd9,  16'd14,   1'b0);
    issue(2'b11, 1'b0, 16'd100,  16'd7,    5'd10, 16'd2,    1'b1);
    issue(2'b10, 1'b0, 16'h1234, 16'h0000, 5'd11, 16'hFFFF, 1'b0);
    issue(2'b11, 1'b0, 16'h1234, 16'h0000, 5'd12, 16'h1234, 1'b0);
    issue(2'b00, 1'b0, 16'h0000, 16'h1234, 5'd13, 16'h0000, 1'b0);
`ifdef MULDIV_SIGNED_EN
    issue(2'b10, 1'b1, 16'hFFF9, 16'h0002, 5'd14, 16'hFFFD, 1'b0);
    issue(2'b11, 1'b1, 16'hFFF9, 16'h0002, 5'd15, 16'hFFFF, 1'b0);
    issue(2'b10, 1'b1, 16'h8000, 16'hFFFF, 5'd16, 16'h8000, 1'b0);
    issue(2'b11, 1'b1, 16'h8000, 16'hFFFF, 5'd17, 16'h0000, 1'b0);
    issue(2'b01, 1'b1, 16'hFFFF, 16'h0003, 5'd18, 16'hFFFF, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom);
      rs = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rw = 5'($urandom);
      issue(ro, rs, ra, rb, rw, model(ro, rs, ra, rb), 1'($urandom_range(0, 3) == 0));
    end

    // Abort an operation with reset; no done may follow
    @(negedge clk);
    op = 2'b00; is_signed = 1'b0; operand_a = 16'd9; operand_b = 16'd9; waddr_in = 5'd21;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 arst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_waddr_o", waddr_o, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (3 * W) @(posedge clk);
    #1;
    check("abort_idle", busy, 0);
    check("abort_result_held", result, 0);

    issue(2'b10, 1'b0, 16'd1000, 16'd33, 5'd5, 16'd30, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file read ports.
- Takes two DATA_W operands (the two register-file read data values) and a destination register address.
- Computes a multiply or divide result over multiple cycles.
- Presents the result together with a write-enable and write address for the register file write port.
- The pipeline stalls on busy while an operation is in flight.

Parameters:
DATA_W, 16, operand/result width in bits; must be >= 4 and even.
CNT_W, $clog2(DATA_W)+1, iteration counter width; derived, do not override.

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
is_signed  input  1  signed-operand select; used only when MULDIV_SIGNED_EN is defined
operand_a  input  DATA_W  multiplicand / dividend (register-file read port 1)
operand_b  input  DATA_W  multiplier / divisor (register-file read port 2)
waddr_in  input  5  destination register for the result
busy  output  1  high in CALC and DONE; pipeline stall request
done  output  1  one-cycle pulse, result valid
result  output  DATA_W  selected result, held until the next accepted start
reg_write_o  output  1  equals done; drives the register-file write enable
waddr_o  output  5  captured waddr_in; held with result

Behaviour:
- States: IDLE, CALC, DONE. All state, counter and datapath registers are flopped on posedge clk and reset asynchronously.
- Reset values: state=IDLE, busy=0, done=0, reg_write_o=0, result=0, waddr_o=0, counter=0.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced for the aborted operation.
- IDLE with start=1 at edge E0:
  - Capture op, is_signed, operands and waddr_in into internal registers.
  - Clear the counter and go to CALC.
  - Input ports are ignored after capture.
- IDLE with start=0: stay in IDLE.
- CALC performs one iteration per cycle:
  - Multiply: shift-add over a 2*DATA_W product register.
  - Divide: restoring divide with a DATA_W remainder and quotient.
- After exactly DATA_W iterations, go to DONE. done rises DATA_W+1 cycles after the start cycle.
- DONE:
  - done=1, reg_write_o=1 for exactly one cycle.
  - The result register is loaded on the edge entering DONE.
  - Next edge returns to IDLE.
- start while busy=1 is ignored; it is not queued. The earliest new start is the cycle after DONE.
- Result select:
  - MUL: product[DATA_W-1:0].
  - MULH: product[2*DATA_W-1:DATA_W].
  - DIV: quotient.
  - REM: remainder.
- Divide by zero, detected at accept:
  - Skip CALC and go to DONE on the next edge (done one cycle after start).
  - Quotient is all ones; remainder equals operand_a.
- Multiply by zero still takes the full DATA_W iterations (no early exit).
- Unsigned arithmetic throughout when the macro is undefined. Overflow is impossible: results are full width.

Optional Feature:
MULDIV_SIGNED_EN
- Defined:
  - With is_signed=1, operands are treated as two's complement.
  - Absolute values are taken at accept, and the sign is fixed on the edge entering DONE.
  - Product sign = sign_a XOR sign_b.
  - Quotient sign = sign_a XOR sign_b; remainder takes the sign of the dividend.
  - Signed divide by zero: quotient all ones (-1), remainder = operand_a.
  - Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0; full latency.
  - Latency is unchanged.
- Undefined: is_signed is ignored, and no sign or absolute-value logic is synthesized.

Test Plan (DATA_W=16):
- MUL: start with op=00, a=3, b=5, waddr_in=7 -> busy from next cycle; done=1, reg_write_o=1 exactly 17 cycles after the start cycle; result=0x000F, waddr_o=7; back in IDLE the following cycle.
- MULH: op=01, a=0xFFFF, b=0xFFFF -> result=0xFFFE. Then op=00 with the same operands -> result=0x0001.
- DIV/REM: op=10, a=100, b=7 -> result=14. Then op=11 -> result=2. start pulsed during CALC is ignored: exactly one done pulse, and the result is unchanged.
- Divide by zero: op=10, a=0x1234, b=0 -> done one cycle after start, result=0xFFFF. op=11 -> result=0x1234.
- Reset mid-op: start MUL, assert arst_n=0 at cycle 5 -> busy=0, done=0, result=0 immediately. After release, IDLE; no done pulse appears.
- With MULDIV_SIGNED_EN:
  - is_signed=1, op=10, a=0xFFF9 (-7), b=2 -> result=0xFFFD. op=11 -> result=0xFFFF.
  - op=10, a=0x8000, b=0xFFFF -> result=0x8000.
